// File: rtl/window_replay_sender.sv
// window_replay_sender: captures one median window from an upstream pixel FIFO
// and replays it on demand through a FIFO-style read port (1-cycle latency).
`default_nettype none

module window_replay_sender #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
    input  logic [7:0]               in_px,
    input  logic                     in_px_empty,
    output logic                     in_px_rd,
    input  logic                     in_px_valid,
    output logic [7:0]               out_px,
    output logic                     out_px_empty,
    input  logic                     out_px_rd,
    output logic                     out_px_valid,
    input  logic                     replay_req,
    // "release" is a reserved word, hence the suffix
    input  logic                     release_win,
    output logic [BUFF_SIZE_BIT-1:0] buff_size_samp,
    output logic                     loaded,
    output logic                     replaying,
    output logic                     pass_done,
    output logic [BUFF_SIZE_BIT-1:0] pass_count
);

    localparam int                       IDX_W    = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
    localparam logic [BUFF_SIZE_BIT-1:0] MAX_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);
    localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2,
        REPLAY = 2'd3
    } state_t;

    state_t                   state;
    logic [7:0]               mem [BUFF_SIZE];
    logic [BUFF_SIZE_BIT-1:0] wr_ptr;
    logic [BUFF_SIZE_BIT-1:0] iss_cnt;
    logic [BUFF_SIZE_BIT-1:0] rd_ptr;

    // Read strobe follows upstream empty combinationally so no request is lost.
    assign in_px_rd     = (state == LOAD) && !in_px_empty && (iss_cnt < buff_size_samp);
    assign out_px_empty = (state != REPLAY) || (rd_ptr == buff_size_samp);
    assign loaded       = (state == READY) || (state == REPLAY);
    assign replaying    = (state == REPLAY);

    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && in_px_valid) begin
            mem[wr_ptr[IDX_W-1:0]] <= in_px;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            out_px         <= 8'd0;
            out_px_valid   <= 1'b0;
            buff_size_samp <= '0;
            pass_done      <= 1'b0;
            pass_count     <= '0;
            wr_ptr         <= '0;
            iss_cnt        <= '0;
            rd_ptr         <= '0;
        end else begin
            pass_done    <= 1'b0;
            out_px_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && in_buff_size != '0) begin
                        buff_size_samp <= (in_buff_size > MAX_SIZE) ? MAX_SIZE : in_buff_size;
                        wr_ptr         <= '0;
                        iss_cnt        <= '0;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_px_rd) begin
                        iss_cnt <= iss_cnt + ONE;
                    end
                    if (in_px_valid) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (wr_ptr + ONE == buff_size_samp) begin
                            state <= READY;
                        end
                    end
                end
                READY: begin
                    if (release_win) begin
                        state      <= IDLE;
                        pass_count <= '0;
                    end else if (replay_req) begin
                        rd_ptr <= '0;
                        state  <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (release_win) begin
                        state      <= IDLE;
                        pass_count <= '0;
                    end else if (rd_ptr == buff_size_samp) begin
                        // Last pixel is on the output this cycle; close the pass.
                        pass_done <= 1'b1;
                        if (pass_count != '1) begin
                            pass_count <= pass_count + ONE;
                        end
                        state <= READY;
                    end else if (out_px_rd) begin
                        out_px       <= mem[rd_ptr[IDX_W-1:0]];
                        out_px_valid <= 1'b1;
                        rd_ptr       <= rd_ptr + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_window_replay_sender.sv
// tb_window_replay_sender: directed + randomized bench with an upstream FIFO model
// and a window reference model (first N pixels of the upstream stream).
`default_nettype none

module tb_window_replay_sender;

    localparam int BS = 32;
    localparam int W  = $clog2(BS) + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in_buff_size;
    logic [7:0]   in_px;
    logic         in_px_empty;
    logic         in_px_rd;
    logic         in_px_valid;
    logic [7:0]   out_px;
    logic         out_px_empty;
    logic         out_px_rd;
    logic         out_px_valid;
    logic         replay_req;
    logic         release_win;
    logic [W-1:0] buff_size_samp;
    logic         loaded;
    logic         replaying;
    logic         pass_done;
    logic [W-1:0] pass_count;

    window_replay_sender #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_buff_size(in_buff_size),
        .in_px(in_px), .in_px_empty(in_px_empty), .in_px_rd(in_px_rd),
        .in_px_valid(in_px_valid), .out_px(out_px), .out_px_empty(out_px_empty),
        .out_px_rd(out_px_rd), .out_px_valid(out_px_valid), .replay_req(replay_req),
        .release_win(release_win), .buff_size_samp(buff_size_samp), .loaded(loaded),
        .replaying(replaying), .pass_done(pass_done), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fifo[$];
    logic [7:0] win[$];
    logic [7:0] got[$];
    logic       stall = 1'b0;
    logic       acc   = 1'b0;
    int         reads = 0;
    int         pd_cnt = 0;
    int         run = 0;
    int         max_run = 0;
    int         exp_pc = 0;

    // Observation of DUT outputs on the falling edge.
    always @(negedge clk) begin
        acc   = in_px_rd;
        reads = reads + (in_px_rd ? 1 : 0);
        if (out_px_valid) begin
            got.push_back(out_px);
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (pass_done) pd_cnt = pd_cnt + 1;
    end

    // Upstream FIFO: data valid one cycle after an accepted read.
    always @(posedge clk) begin
        #2;
        if (acc && fifo.size() > 0) begin
            in_px       = fifo.pop_front();
            in_px_valid = 1'b1;
        end else begin
            in_px_valid = 1'b0;
        end
        in_px_empty = stall || (fifo.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_px_rd"}, 32'(in_px_rd), 0);
        check({pfx, "_out_px"}, 32'(out_px), 0);
        check({pfx, "_out_px_valid"}, 32'(out_px_valid), 0);
        check({pfx, "_out_px_empty"}, 32'(out_px_empty), 1);
        check({pfx, "_buff_size_samp"}, 32'(buff_size_samp), 0);
        check({pfx, "_loaded"}, 32'(loaded), 0);
        check({pfx, "_replaying"}, 32'(replaying), 0);
        check({pfx, "_pass_done"}, 32'(pass_done), 0);
        check({pfx, "_pass_count"}, 32'(pass_count), 0);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) fifo.push_back(8'($urandom));
    endtask

    task automatic load(input int size, input bit do_stall);
        int n;
        int r0;
        n = (size > BS) ? BS : size;
        win.delete();
        for (int i = 0; i < n; i++) win.push_back(fifo[i]);
        r0           = reads;
        start        = 1'b1;
        in_buff_size = W'(size);
        tick();
        start = 1'b0;
        for (int c = 0; c < 300 && !loaded; c++) begin
            if (do_stall) stall = (c >= 1 && c <= 3);
            tick();
        end
        stall = 1'b0;
        check("load_done", 32'(loaded), 1);
        check("load_size_samp", 32'(buff_size_samp), 32'(n));
        check("load_upstream_reads", 32'(reads - r0), 32'(n));
        check("load_out_empty", 32'(out_px_empty), 1);
        exp_pc = 0;
    endtask

    task automatic run_pass(input int mode);
        int n;
        int pd0;
        int r0;
        n   = win.size();
        got.delete();
        max_run    = 0;
        pd0        = pd_cnt;
        r0         = reads;
        replay_req = 1'b1;
        tick();
        replay_req = 1'b0;
        check("pass_replaying", 32'(replaying), 1);
        for (int c = 0; c < 400 && pd_cnt == pd0; c++) begin
            case (mode)
                0:       out_px_rd = 1'b1;
                1:       out_px_rd = (c % 2 == 0);
                default: out_px_rd = 1'($urandom_range(0, 1));
            endcase
            tick();
        end
        out_px_rd = 1'b0;
        tick();
        exp_pc++;
        check("pass_done_pulses", 32'(pd_cnt - pd0), 1);
        check("pass_px_count", 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("pass_px%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx,
                  32'(win[i]));
        end
        if (mode == 0) check("pass_back_to_back", 32'(max_run), 32'(n));
        check("pass_count", 32'(pass_count), 32'(exp_pc));
        check("pass_out_empty", 32'(out_px_empty), 1);
        check("pass_not_replaying", 32'(replaying), 0);
        check("pass_still_loaded", 32'(loaded), 1);
        check("pass_no_upstream", 32'(reads - r0), 0);
    endtask

    task automatic do_release();
        release_win = 1'b1;
        tick();
        release_win = 1'b0;
        exp_pc = 0;
        check("rel_loaded", 32'(loaded), 0);
        check("rel_pass_count", 32'(pass_count), 0);
        check("rel_replaying", 32'(replaying), 0);
    endtask

    initial begin
        int pd0;
        int r0;
        rst = 1'b1; start = 1'b0; in_buff_size = '0; in_px = 8'd0; in_px_empty = 1'b1;
        in_px_valid = 1'b0; out_px_rd = 1'b0; replay_req = 1'b0; release_win = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Zero-size start is ignored even with data waiting upstream.
        fifo = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        tick();
        start = 1'b1; in_buff_size = '0;
        tick();
        start = 1'b0;
        tick();
        check("start0_loaded", 32'(loaded), 0);
        check("start0_in_px_rd", 32'(in_px_rd), 0);
        check("start0_reads", 32'(reads), 0);

        load(5, 1'b0);
        run_pass(0);
        run_pass(0);
        do_release();

        // Oversized request clamps to storage depth.
        push_rand(40);
        load(40, 1'b0);
        run_pass(0);
        run_pass(2);
        do_release();

        // Upstream stalls during load, throttled consumer during replay.
        push_rand(7);
        load(7, 1'b1);
        run_pass(1);
        do_release();

        // Abort after two pixels, release concurrent with a third read.
        push_rand(5);
        load(5, 1'b0);
        got.delete();
        pd0 = pd_cnt;
        replay_req = 1'b1;
        tick();
        replay_req = 1'b0;
        out_px_rd  = 1'b1;
        tick();
        tick();
        release_win = 1'b1;
        tick();
        release_win = 1'b0;
        out_px_rd   = 1'b0;
        check("abort_valid_next", 32'(out_px_valid), 0);
        check("abort_replaying", 32'(replaying), 0);
        check("abort_loaded", 32'(loaded), 0);
        check("abort_pass_count", 32'(pass_count), 0);
        check("abort_out_empty", 32'(out_px_empty), 1);
        tick();
        check("abort_valid_later", 32'(out_px_valid), 0);
        check("abort_px_seen", 32'(got.size()), 2);
        check("abort_no_pass_done", 32'(pd_cnt - pd0), 0);
        push_rand(4);
        load(4, 1'b0);
        run_pass(2);
        do_release();

        // Reset mid-load; the in-flight upstream pixel arrives after reset.
        push_rand(8);
        r0 = reads;
        start = 1'b1; in_buff_size = W'(8);
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && (reads - r0) < 3; c++) tick();
        check("midload_reads", 32'(reads - r0), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midload_rst");
        #2;
        load(1, 1'b0);
        run_pass(0);
        do_release();

        // Randomized windows.
        for (int k = 0; k < 4; k++) begin
            int sz;
            sz = int'($urandom_range(1, 45));
            push_rand(sz);
            load(sz, 1'b0);
            run_pass(int'($urandom_range(0, 2)));
            run_pass(int'($urandom_range(0, 2)));
            do_release();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/window_replay_sender.md
Name: window_replay_sender

Overview:
- Transmit side of the pixel FIFO interface that fill_buffers consumes.
- Captures one median window of up to BUFF_SIZE pixels from the upstream pixel FIFO into local storage.
- Replays the whole window on demand, once per quickselect pass, through a FIFO-style read port (empty/rd/valid, 1-cycle read latency).
- Holds the window until the median control releases it.

Parameters:
BUFF_SIZE, 32, maximum window size in pixels; storage depth.
BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size, pointer and count values (must represent BUFF_SIZE itself).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  pulse; samples in_buff_size and begins load (honoured only in IDLE).
in_buff_size  input  BUFF_SIZE_BIT  requested window size.
in_px  input  8  upstream FIFO data, valid when in_px_valid=1.
in_px_empty  input  1  upstream FIFO empty.
in_px_rd  output  1  upstream read strobe.
in_px_valid  input  1  upstream data valid, exactly 1 cycle after an accepted in_px_rd.
out_px  output  8  replayed pixel (registered).
out_px_empty  output  1  no pixel available to the consumer.
out_px_rd  input  1  consumer read strobe.
out_px_valid  output  1  out_px valid, 1 cycle after an accepted out_px_rd.
replay_req  input  1  pulse; start one full pass (honoured only in READY).
release  input  1  discard window, return to IDLE.
buff_size_samp  output  BUFF_SIZE_BIT  sampled, clamped window size.
loaded  output  1  window fully stored (READY or REPLAY).
replaying  output  1  state == REPLAY.
pass_done  output  1  1-cycle pulse at end of each pass.
pass_count  output  BUFF_SIZE_BIT  completed passes on current window; saturating.

Behaviour:
Interface decision:
- One clock, clk. Reset rst is synchronous and active-high.

Reset (rst=1 at clk edge):
- State goes to IDLE.
- in_px_rd=0, out_px=0, out_px_valid=0, out_px_empty=1, buff_size_samp=0, loaded=0, replaying=0, pass_done=0, pass_count=0.
- Pointers and counters clear. Storage contents are not reset.
- Reset mid-load or mid-replay aborts immediately. Any in_px_valid arriving the cycle after reset is ignored.

Storage:
- BUFF_SIZE x 8 register array.
- Write pointer wr_ptr, issued-read count iss_cnt, replay pointer rd_ptr.

FSM states: IDLE, LOAD, READY, REPLAY.
- IDLE:
  - start=1 with in_buff_size=0 is ignored (remain IDLE).
  - start=1 with in_buff_size>0: buff_size_samp <= min(in_buff_size, BUFF_SIZE); go to LOAD.
- LOAD:
  - in_px_rd = ~in_px_empty & (iss_cnt < buff_size_samp); iss_cnt increments on each strobe.
  - On in_px_valid: mem[wr_ptr] <= in_px, wr_ptr++.
  - When wr_ptr reaches buff_size_samp: go to READY, loaded=1.
  - release and replay_req are ignored in LOAD; the window must be fully consumed from upstream.
- READY:
  - out_px_empty=1.
  - release=1: go to IDLE, loaded=0, pass_count=0. release wins over a simultaneous replay_req.
  - Otherwise replay_req=1: rd_ptr=0, go to REPLAY.
- REPLAY:
  - out_px_empty = (rd_ptr == buff_size_samp).
  - out_px_rd=1 while not empty: out_px <= mem[rd_ptr], out_px_valid=1 next cycle, rd_ptr++.
  - out_px_rd while empty has no effect and produces no valid.
  - Back-to-back reads sustain 1 pixel/cycle. Gaps in out_px_rd stall the replay without loss.
  - When rd_ptr == buff_size_samp and the last valid has been presented: pass_done=1 for one cycle, pass_count++ (saturating at all ones), go to READY.
  - release in REPLAY aborts: go to IDLE next cycle, out_px_valid=0 from the following cycle, loaded=0, pass_count=0, no pass_done.
  - replay_req in REPLAY is ignored.
- start is ignored outside IDLE.

Pixel ordering:
- Replay order equals load order.
- Every pass emits exactly buff_size_samp pixels.

Test Plan:
- size=5, FIFO preloaded 10,20,30,40,50; start; replay_req; out_px_rd held high -> in_px_rd asserted exactly 5 times; out_px_valid for 5 consecutive cycles with 10,20,30,40,50; pass_done once; pass_count=1; out_px_empty=1.
- Second replay_req on the same window -> identical sequence 10..50 with no upstream reads; pass_count=2.
- size=40 with BUFF_SIZE=32 -> buff_size_samp=32; exactly 32 upstream reads; each replay emits 32 pixels.
- Replay with out_px_rd toggling 1,0,1,0 and upstream empty for 3 cycles during load -> no pixel lost or duplicated; ordering preserved.
- release asserted after 2 of 5 pixels replayed -> IDLE; out_px_valid low 2 cycles later; no pass_done; pass_count=0; loaded=0; a new start loads a fresh window correctly.
- rst=1 mid-LOAD after 3 of 8 pixels, with in_px_valid high the next cycle -> all outputs at reset values; late valid ignored; subsequent start with size=1 -> single pixel replayed.
